// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-memory fetch sequencer for the AVR core.
// Fetches one instruction at a time with no prefetch. It assembles the
// two-word forms (jmp/call/lds/sts) into one issue, drops skipped
// instructions, and redirects on taken branches. A read that is still
// outstanding when a branch arrives is drained before the new fetch.
// Optional macro FETCH_SEQ_STATS_EN adds the stat_issued and stat_skipped
// counters and their ports.
module fetch_sequencer #(
   parameter int                     PC_WIDTH     = 16,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [PC_WIDTH-1:0]  pmem_addr,
   output logic                 pmem_rd,
   input  logic [15:0]          pmem_data,
   input  logic                 pmem_valid,
   output logic [15:0]          instr_word,
   output logic [15:0]          instr_operand,
   output logic [PC_WIDTH-1:0]  instr_pc,
   output logic                 instr_valid,
   input  logic                 exec_ready,
   input  logic                 skip_req,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target
`ifdef FETCH_SEQ_STATS_EN
   ,
   output logic [31:0]          stat_issued,
   output logic [15:0]          stat_skipped
`endif
);

   typedef enum logic [2:0] {
      S_FETCH1, S_WAIT1, S_FETCH2, S_WAIT2, S_ISSUE, S_FLUSH
   } state_t;

   state_t               r_state, w_next_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic [PC_WIDTH-1:0]  r_ipc;
   logic [15:0]          r_word;
   logic [15:0]          r_operand;
   logic                 r_two;
   logic                 r_skip_pending;

   logic                 w_two;
   logic                 w_accept;
   logic                 w_skip_now;
   logic                 w_outstanding;
   logic [PC_WIDTH-1:0]  w_pc_plus1;
   logic [PC_WIDTH-1:0]  w_pc_plus2;
   logic [PC_WIDTH-1:0]  w_pc_next_len;

   // An opcode needs a second word for jmp/call (1001010 ... 11x) and for lds/sts (100100x ... 0000).
   function automatic logic is_two_word(input logic [15:0] w);
      return ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11)) ||
             (((w[15:9] == 7'b1001000) || (w[15:9] == 7'b1001001)) && (w[3:0] == 4'b0000));
   endfunction

   assign w_two         = is_two_word(pmem_data);
   assign w_accept      = (r_state == S_ISSUE) && exec_ready;
   assign w_skip_now    = r_skip_pending || skip_req;
   assign w_outstanding = ((r_state == S_WAIT1) || (r_state == S_WAIT2) || (r_state == S_FLUSH))
                          && !pmem_valid;
   assign w_pc_plus1    = r_pc + PC_WIDTH'(1);
   assign w_pc_plus2    = r_pc + PC_WIDTH'(2);
   assign w_pc_next_len = r_two ? w_pc_plus2 : w_pc_plus1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH1;
      else        r_state <= w_next_state;
   end

   // Next-state logic; a branch overrides everything else and drains any outstanding read.
   always_comb begin
      // NOTE: default first so that every path assigns it and no latch is inferred.
      w_next_state = r_state;
      if (branch_taken) begin
         w_next_state = w_outstanding ? S_FLUSH : S_FETCH1;
      end else begin
         case (r_state)
            S_FETCH1: w_next_state = S_WAIT1;
            S_WAIT1:  if (pmem_valid) w_next_state = w_skip_now ? S_FETCH1 :
                                                     (w_two ? S_FETCH2 : S_ISSUE);
            S_FETCH2: w_next_state = S_WAIT2;
            S_WAIT2:  if (pmem_valid) w_next_state = w_skip_now ? S_FETCH1 : S_ISSUE;
            S_ISSUE:  if (exec_ready || skip_req) w_next_state = S_FETCH1;
            S_FLUSH:  if (pmem_valid) w_next_state = S_FETCH1;
            default:  w_next_state = S_FETCH1;
         endcase
      end
   end

   // Output decode. The read strobe is gated by rst_n so that it stays low while reset is held.
   always_comb begin
      pmem_rd     = 1'b0;
      pmem_addr   = '0;
      instr_valid = (r_state == S_ISSUE);
      if (rst_n && (r_state == S_FETCH1)) begin
         pmem_rd   = 1'b1;
         pmem_addr = r_pc;
      end else if (rst_n && (r_state == S_FETCH2)) begin
         pmem_rd   = 1'b1;
         pmem_addr = w_pc_plus1;
      end
   end

   assign instr_word    = r_word;
   assign instr_operand = r_operand;
   assign instr_pc      = r_ipc;

   // Datapath: PC, latched instruction words, and the pending-skip flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc           <= RESET_VECTOR;
         r_ipc          <= '0;
         r_word         <= '0;
         r_operand      <= '0;
         r_two          <= 1'b0;
         r_skip_pending <= 1'b0;
      end else if (branch_taken) begin
         // NOTE: non-blocking assignments keep every register update in step with the same edge.
         r_pc           <= branch_target;
         r_skip_pending <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT1: begin
               if (pmem_valid && w_skip_now) begin
                  r_skip_pending <= 1'b0;
                  r_pc           <= w_two ? w_pc_plus2 : w_pc_plus1;
               end else if (pmem_valid) begin
                  r_word    <= pmem_data;
                  r_ipc     <= r_pc;
                  r_two     <= w_two;
                  r_operand <= '0;
               end else if (skip_req) begin
                  r_skip_pending <= 1'b1;
               end
            end
            S_WAIT2: begin
               if (pmem_valid && w_skip_now) begin
                  r_skip_pending <= 1'b0;
                  r_pc           <= w_pc_plus2;
               end else if (pmem_valid) begin
                  r_operand <= pmem_data;
               end else if (skip_req) begin
                  r_skip_pending <= 1'b1;
               end
            end
            S_ISSUE: begin
               // An accepted instruction passes the skip on to the next one; an unaccepted one is withdrawn.
               if (exec_ready) begin
                  r_pc <= w_pc_next_len;
                  if (skip_req) r_skip_pending <= 1'b1;
               end else if (skip_req) begin
                  r_pc <= w_pc_next_len;
               end
            end
            default: begin
               if (skip_req) r_skip_pending <= 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_SEQ_STATS_EN
   logic [31:0] r_stat_issued;
   logic [15:0] r_stat_skipped;
   logic        w_skip_event;

   assign w_skip_event = !branch_taken &&
                         ((((r_state == S_WAIT1) || (r_state == S_WAIT2)) && pmem_valid && w_skip_now) ||
                          ((r_state == S_ISSUE) && !exec_ready && skip_req));

   // Saturating counters of accepted and discarded instructions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_issued  <= '0;
         r_stat_skipped <= '0;
      end else begin
         if (!branch_taken && w_accept && (r_stat_issued != '1))
            r_stat_issued <= r_stat_issued + 32'd1;
         if (w_skip_event && (r_stat_skipped != '1))
            r_stat_skipped <= r_stat_skipped + 16'd1;
      end
   end

   assign stat_issued  = r_stat_issued;
   assign stat_skipped = r_stat_skipped;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with a variable-latency memory model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pmem_addr;
   logic        pmem_rd;
   logic [15:0] pmem_data;
   logic        pmem_valid;
   logic [15:0] instr_word;
   logic [15:0] instr_operand;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        exec_ready;
   logic        skip_req;
   logic        branch_taken;
   logic [15:0] branch_target;
`ifdef FETCH_SEQ_STATS_EN
   logic [31:0] stat_issued;
   logic [15:0] stat_skipped;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int lat      = 1;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] word;
      logic [15:0] op;
   } iss_t;

   iss_t        iss_q[$];
   logic [15:0] rd_q[$];
   logic        stale_seen;
   logic [15:0] mem [0:1023];

   logic        m_busy;
   int          m_cnt;
   logic [15:0] m_addr;

   fetch_sequencer #(.PC_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .pmem_addr(pmem_addr), .pmem_rd(pmem_rd),
      .pmem_data(pmem_data), .pmem_valid(pmem_valid),
      .instr_word(instr_word), .instr_operand(instr_operand),
      .instr_pc(instr_pc), .instr_valid(instr_valid),
      .exec_ready(exec_ready), .skip_req(skip_req),
      .branch_taken(branch_taken), .branch_target(branch_target)
`ifdef FETCH_SEQ_STATS_EN
      , .stat_issued(stat_issued), .stat_skipped(stat_skipped)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: one read in flight, data returned lat cycles after the request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pmem_valid <= 1'b0;
         pmem_data  <= '0;
         m_busy     <= 1'b0;
         m_cnt      <= 0;
         m_addr     <= '0;
      end else begin
         pmem_valid <= 1'b0;
         if (m_busy) begin
            if (m_cnt <= 1) begin
               pmem_valid <= 1'b1;
               pmem_data  <= mem[m_addr[9:0]];
               m_busy     <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (pmem_rd) begin
            if (lat <= 1) begin
               pmem_valid <= 1'b1;
               pmem_data  <= mem[pmem_addr[9:0]];
            end else begin
               m_busy <= 1'b1;
               m_addr <= pmem_addr;
               m_cnt  <= lat - 1;
            end
         end
      end
   end

   // Record read requests, accepted instructions and any appearance of the stale marker word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pmem_rd) rd_q.push_back(pmem_addr);
         if (instr_valid && exec_ready && !branch_taken)
            iss_q.push_back('{pc: instr_pc, word: instr_word, op: instr_operand});
         if (instr_valid && (instr_word == 16'hBEEF)) stale_seen = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
   endtask

   task automatic hold_reset();
      rst_n         = 1'b0;
      exec_ready    = 1'b1;
      skip_req      = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      repeat (2) tick();
      iss_q.delete();
      rd_q.delete();
      stale_seen = 1'b0;
   endtask

   task automatic release_reset();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_iss(input int n, input string name);
      int cyc = 0;
      while ((iss_q.size() < n) && (cyc < 300)) begin
         @(negedge clk);
         cyc++;
      end
      if (iss_q.size() < n) begin
         n_checks++; n_errors++;
         $display("FAIL %s: timeout, issued %0d required %0d", name, iss_q.size(), n);
      end
   endtask

   task automatic wait_rd(input int n, input string name);
      int cyc = 0;
      while ((rd_q.size() < n) && (cyc < 300)) begin
         @(negedge clk);
         cyc++;
      end
      if (rd_q.size() < n) begin
         n_checks++; n_errors++;
         $display("FAIL %s: timeout, reads %0d required %0d", name, rd_q.size(), n);
      end
   endtask

   task automatic test_reset();
      clear_mem();
      mem[0] = 16'hE50F;
      mem[1] = 16'h0000;
      lat = 1;
      hold_reset();
      n_checks++;
      if ({pmem_rd, pmem_addr, instr_valid, instr_word, instr_operand, instr_pc} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: rd=%b addr=%h v=%b w=%h op=%h pc=%h required all 0",
                  pmem_rd, pmem_addr, instr_valid, instr_word, instr_operand, instr_pc);
      end
      release_reset();
      #1;
      n_checks++;
      if (pmem_rd !== 1'b1 || pmem_addr !== 16'h0000) begin
         n_errors++;
         $display("FAIL first_read: rd=%b addr=%h required rd=1 addr=0000", pmem_rd, pmem_addr);
      end
      wait_iss(1, "reset_issue");
      n_checks++;
      if (iss_q[0].word !== 16'hE50F || iss_q[0].op !== 16'h0000 || iss_q[0].pc !== 16'h0000) begin
         n_errors++;
         $display("FAIL ldi_issue: w=%h op=%h pc=%h required E50F 0000 0000",
                  iss_q[0].word, iss_q[0].op, iss_q[0].pc);
      end
      wait_rd(2, "reset_next_read");
      n_checks++;
      if (rd_q[1] !== 16'h0001) begin
         n_errors++;
         $display("FAIL next_addr: addr=%h required 0001", rd_q[1]);
      end
   endtask

   task automatic test_two_word();
      clear_mem();
      mem[0] = 16'hE50F;
      mem[1] = 16'h0000;
      mem[2] = 16'h940C;
      mem[3] = 16'h0010;
      mem[4] = 16'hE001;
      lat = 1;
      hold_reset();
      release_reset();
      wait_iss(4, "jmp_issue");
      n_checks++;
      if (iss_q[2].word !== 16'h940C || iss_q[2].op !== 16'h0010 || iss_q[2].pc !== 16'h0002) begin
         n_errors++;
         $display("FAIL jmp_issue: w=%h op=%h pc=%h required 940C 0010 0002",
                  iss_q[2].word, iss_q[2].op, iss_q[2].pc);
      end
      n_checks++;
      if (iss_q[3].pc !== 16'h0004 || iss_q[3].word !== 16'hE001 || iss_q[3].op !== 16'h0000) begin
         n_errors++;
         $display("FAIL after_jmp: pc=%h w=%h op=%h required 0004 E001 0000",
                  iss_q[3].pc, iss_q[3].word, iss_q[3].op);
      end
      n_checks++;
      if (rd_q[2] !== 16'h0002 || rd_q[3] !== 16'h0003 || rd_q[4] !== 16'h0004) begin
         n_errors++;
         $display("FAIL jmp_reads: %h %h %h required 0002 0003 0004", rd_q[2], rd_q[3], rd_q[4]);
      end
   endtask

   task automatic test_skip(input logic [15:0] w5, input logic [15:0] exp_pc, input string name);
      clear_mem();
      for (int i = 0; i < 4; i++) mem[i] = 16'hE000 + 16'(i);
      mem[4] = 16'h1300;
      mem[5] = w5;
      mem[6] = 16'hE066;
      mem[7] = 16'h0000;
      lat = 1;
      hold_reset();
      release_reset();
      wait_iss(5, name);
      tick();
      skip_req = 1'b1;
      tick();
      skip_req = 1'b0;
      wait_iss(6, name);
      n_checks++;
      if (iss_q[5].pc !== exp_pc || iss_q[5].word !== mem[exp_pc[9:0]]) begin
         n_errors++;
         $display("FAIL %s: pc=%h w=%h required pc=%h w=%h",
                  name, iss_q[5].pc, iss_q[5].word, exp_pc, mem[exp_pc[9:0]]);
      end
      n_checks++;
      if (rd_q[6] !== exp_pc) begin
         n_errors++;
         $display("FAIL %s_read: addr=%h required %h", name, rd_q[6], exp_pc);
      end
   endtask

   task automatic test_branch_flush();
      clear_mem();
      mem[0]     = 16'hBEEF;
      mem[10'h100] = 16'hE123;
      lat = 3;
      hold_reset();
      release_reset();
      tick();
      branch_taken  = 1'b1;
      branch_target = 16'h0100;
      tick();
      branch_taken = 1'b0;
      wait_iss(1, "branch_issue");
      n_checks++;
      if (rd_q.size() < 2 || rd_q[1] !== 16'h0100) begin
         n_errors++;
         $display("FAIL branch_addr: reads=%0d addr=%h required 0100", rd_q.size(), rd_q[1]);
      end
      n_checks++;
      if (iss_q[0].pc !== 16'h0100 || iss_q[0].word !== 16'hE123) begin
         n_errors++;
         $display("FAIL branch_issue: pc=%h w=%h required 0100 E123", iss_q[0].pc, iss_q[0].word);
      end
      n_checks++;
      if (stale_seen !== 1'b0) begin
         n_errors++;
         $display("FAIL stale_word: seen=%b required 0", stale_seen);
      end
   endtask

   task automatic test_hold_withdraw();
      int cyc = 0;
      clear_mem();
      mem[0] = 16'h2400;
      mem[1] = 16'hE001;
      lat = 1;
      hold_reset();
      exec_ready = 1'b0;
      release_reset();
      while (!instr_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (instr_valid !== 1'b1 || instr_word !== 16'h2400 || instr_pc !== 16'h0000) begin
            n_errors++;
            $display("FAIL hold_%0d: v=%b w=%h pc=%h required 1 2400 0000",
                     i, instr_valid, instr_word, instr_pc);
         end
      end
      tick();
      skip_req = 1'b1;
      tick();
      skip_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL withdraw_valid: v=%b required 0", instr_valid);
      end
      exec_ready = 1'b1;
      wait_iss(1, "withdraw_next");
      n_checks++;
      if (iss_q[0].pc !== 16'h0001 || iss_q[0].word !== 16'hE001 || rd_q[1] !== 16'h0001) begin
         n_errors++;
         $display("FAIL withdraw_next: pc=%h w=%h rd=%h required 0001 E001 0001",
                  iss_q[0].pc, iss_q[0].word, rd_q[1]);
      end
   endtask

   task automatic test_reset_mid();
      clear_mem();
      mem[0] = 16'hE50F;
      mem[1] = 16'h940C;
      mem[2] = 16'h1234;
      lat = 3;
      hold_reset();
      release_reset();
      wait_rd(3, "mid_reach_wait2");
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pmem_rd, pmem_addr, instr_valid, instr_word, instr_operand, instr_pc} !== '0) begin
         n_errors++;
         $display("FAIL mid_reset: rd=%b addr=%h v=%b w=%h op=%h pc=%h required all 0",
                  pmem_rd, pmem_addr, instr_valid, instr_word, instr_operand, instr_pc);
      end
      hold_reset();
      release_reset();
      wait_iss(1, "mid_restart");
      n_checks++;
      if (rd_q[0] !== 16'h0000 || iss_q[0].pc !== 16'h0000 || iss_q[0].word !== 16'hE50F) begin
         n_errors++;
         $display("FAIL mid_restart: rd=%h pc=%h w=%h required 0000 0000 E50F",
                  rd_q[0], iss_q[0].pc, iss_q[0].word);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      exec_ready    = 1'b1;
      skip_req      = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      stale_seen    = 1'b0;
      test_reset();
      test_two_word();
      test_skip(16'h940E, 16'h0007, "skip_call");
      test_skip(16'h0000, 16'h0006, "skip_nop");
      test_branch_flush();
      test_hold_withdraw();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
